id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-forwarding stage directly upstream of the EX-stage ALU.
- Captures decoded instruction fields from ID under a valid/ready handshake.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a bubble.
- Drives the ALU operands (A, B) and the ALU opcode (alu_op_t).

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID presents an instruction
id_ready  out  1  stage accepts the ID instruction this cycle
id_rs_data  in  DATA_W  register-file rs read value
id_rt_data  in  DATA_W  register-file rt read value
id_imm  in  DATA_W  extended immediate
id_rs  in  REG_AW  rs address
id_rt  in  REG_AW  rt address
id_dst  in  REG_AW  destination register
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_alu_op  in  alu_op_t  ALU operation
id_alusrc_imm  in  1  B operand = immediate
id_reg_write  in  1  writes register file
id_mem_read  in  1  load
id_mem_write  in  1  store
flush  in  1  kill held instruction and the ID transfer this cycle
exmem_reg_write  in  1  EX/MEM instruction writes back
exmem_dst  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB instruction writes back
memwb_dst  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB write-back value
ex_ready  in  1  EX/MEM accepts the held instruction
ex_valid  out  1  held instruction valid
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_op  out  alu_op_t  ALU control
store_data  out  DATA_W  forwarded rt value for stores
ex_dst  out  REG_AW  destination
ex_reg_write  out  1  gated by ex_valid
ex_mem_read  out  1  gated by ex_valid
ex_mem_write  out  1  gated by ex_valid
load_use_stall  out  1  hazard stall indicator

Behaviour:
- Reset (rst_n low, asynchronous):
  - ex_valid=0.
  - All held fields 0; held op = ALU_ADD.
  - Consequently alu_a=alu_b=store_data=0, ex_dst=0, and all control outputs 0.
- Hazard detection (combinational, relative to the held instruction):
  - hazard = ex_valid & held_mem_read & (held_dst!=0) & id_valid & ((id_use_rs & id_rs==held_dst) | (id_use_rt & id_rt==held_dst)).
  - load_use_stall = hazard.
- Ready: id_ready = (ex_ready | ~ex_valid) & ~hazard.
- Register update on the rising clock edge, in priority order:
  1. flush: ex_valid<=0.
  2. id_valid & id_ready: capture all id_* fields; ex_valid<=1.
  3. hazard & ex_ready: ex_valid<=0 (bubble).
  4. ex_ready: ex_valid<=0.
  5. Otherwise: hold.
- Latency: one cycle from ID acceptance to ALU operands.
- A stalled ID instruction is presented again the cycle after the bubble, and then forwards from EX/MEM.
- Forwarding (combinational, per source held_rs/held_rt):
  - Address 0 is never forwarded; it yields the captured register-file value.
  - EX/MEM match (exmem_reg_write & exmem_dst==src): use exmem_result. EX/MEM wins over MEM/WB.
  - Else MEM/WB match: use memwb_result.
  - Else: use the captured register data.
- Output muxing:
  - alu_a = forwarded rs.
  - alu_b = held_alusrc_imm ? held_imm : forwarded rt.
  - store_data = forwarded rt, independent of alusrc_imm.
- Output gating:
  - ex_reg_write, ex_mem_read and ex_mem_write are ANDed with ex_valid.
  - alu_op, alu_a and alu_b are not gated.
- Simultaneous events:
  - flush together with an accepted transfer: flush wins and the ID instruction is dropped.
  - Reset mid-stall: immediate clear; no bubble or instruction survives.
- Arithmetic: none; widths are exact. DATA_W values pass through unmodified.

Decomposition:
- mips_pkg: alu_op_t (existing) plus a new id_ex_t packed struct for the held fields.
- mips_pkg: constant REG_ZERO = 5'd0.
- Sub-module fwd_mux: one instance per source operand.
  - Inputs: src address, register data, EX/MEM and MEM/WB ports.
  - Output: forwarded value.

Test Plan:
- Reset, then no input: ex_valid=0, alu_a=alu_b=0, alu_op=ALU_ADD, id_ready=1.
- add $3,$1,$2 with rs_data=5, rt_data=7, no forwarding, ex_ready=1: next cycle ex_valid=1, alu_a=5, alu_b=7, alu_op=ALU_ADD, ex_dst=3.
- Held rs=$4 while exmem writes $4=0x11 and memwb writes $4=0x22: alu_a=0x11. Drop the exmem match: alu_a=0x22. rs=$0 with both writing $0: alu_a=captured value.
- Held lw $5 while ID presents sub $6,$5,$1:
  - Stall cycle: id_ready=0, load_use_stall=1.
  - Next cycle: ex_valid=0 (bubble).
  - Following cycle: sub captured; with exmem $5=0x99, alu_a=0x99, alu_op=ALU_SUB.
- ex_ready=0 for 3 cycles with id_valid=1: id_ready=0 and outputs stable. flush=1 together with id_valid=1: ex_valid=0 next cycle and the ID instruction is not captured.
- sw with alusrc_imm=1, imm=0x10, rt forwarded memwb=0xAB: alu_b=0x10, store_data=0xAB, ex_mem_write=1. Assert rst_n=0 mid-cycle: outputs clear immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS-style pipeline: ALU opcodes, the ID/EX held-field
// bundle and the forwarding match helper.
package mips_pkg;

  localparam int unsigned DATA_W_P = 32;
  localparam int unsigned REG_AW_P = 5;

  // Register $0 is hard-wired to zero and never a forwarding target.
  localparam logic [REG_AW_P-1:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_t;

  // Fields captured from ID and held for the EX stage.
  typedef struct packed {
    logic [DATA_W_P-1:0] rs_data;
    logic [DATA_W_P-1:0] rt_data;
    logic [DATA_W_P-1:0] imm;
    logic [REG_AW_P-1:0] rs;
    logic [REG_AW_P-1:0] rt;
    logic [REG_AW_P-1:0] dst;
    alu_op_t             alu_op;
    logic                alusrc_imm;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } id_ex_t;

  // True when a writing stage targets the source register (never for $0).
  function automatic logic fwd_hit(input logic                wr,
                                   input logic [REG_AW_P-1:0] dst,
                                   input logic [REG_AW_P-1:0] src);
    return wr && (dst == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: selects the newest value of one source register
// from EX/MEM, MEM/WB or the captured register-file read.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_dst,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_dst,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_fwd
);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    o_fwd = i_reg_data;
    if (fwd_hit(i_exmem_reg_write, i_exmem_dst, i_src)) begin
      o_fwd = i_exmem_result;
    end else if (fwd_hit(i_memwb_reg_write, i_memwb_dst, i_src)) begin
      o_fwd = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand
// forwarding feeding the EX-stage ALU.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  alu_op_t           id_alu_op,
  input  logic              id_alusrc_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_dst,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_dst,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output alu_op_t           alu_op,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  id_ex_t            r_held;
  id_ex_t            w_held_d;
  logic              r_valid;
  logic              w_valid_d;
  logic              w_hazard;
  logic              w_accept;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A held load whose destination an incoming instruction reads must not be
  // bypassed: its data only exists after MEM, so ID waits one bubble.
  always_comb begin
    w_hazard = r_valid && r_held.mem_read && (r_held.dst != REG_ZERO) && id_valid &&
               ((id_use_rs && (id_rs == r_held.dst)) || (id_use_rt && (id_rt == r_held.dst)));
    id_ready = (ex_ready || !r_valid) && !w_hazard;
    w_accept = id_valid && id_ready;
  end

  // Next-state: flush beats a transfer; otherwise capture, drain, or hold.
  always_comb begin
    w_held_d  = r_held;
    w_valid_d = r_valid;
    if (flush) begin
      w_valid_d = 1'b0;
    end else if (w_accept) begin
      w_held_d.rs_data    = id_rs_data;
      w_held_d.rt_data    = id_rt_data;
      w_held_d.imm        = id_imm;
      w_held_d.rs         = id_rs;
      w_held_d.rt         = id_rt;
      w_held_d.dst        = id_dst;
      w_held_d.alu_op     = id_alu_op;
      w_held_d.alusrc_imm = id_alusrc_imm;
      w_held_d.reg_write  = id_reg_write;
      w_held_d.mem_read   = id_mem_read;
      w_held_d.mem_write  = id_mem_write;
      w_valid_d           = 1'b1;
    end else if (w_hazard && ex_ready) begin
      // Bubble: the load moves on, the dependent instruction stays in ID.
      w_valid_d = 1'b0;
    end else if (ex_ready) begin
      w_valid_d = 1'b0;
    end
  end

  // Pipeline register; reset clears every held field (opcode becomes ALU_ADD).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_held  <= w_held_d;
      r_valid <= w_valid_d;
    end
  end

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .i_src             (r_held.rs),
    .i_reg_data        (r_held.rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_dst       (exmem_dst),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_dst       (memwb_dst),
    .i_memwb_result    (memwb_result),
    .o_fwd             (w_fwd_rs)
  );

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .i_src             (r_held.rt),
    .i_reg_data        (r_held.rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_dst       (exmem_dst),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_dst       (memwb_dst),
    .i_memwb_result    (memwb_result),
    .o_fwd             (w_fwd_rt)
  );

  // Datapath outputs are ungated; side-effecting controls are qualified by valid.
  always_comb begin
    ex_valid       = r_valid;
    alu_a          = w_fwd_rs;
    alu_b          = r_held.alusrc_imm ? r_held.imm : w_fwd_rt;
    store_data     = w_fwd_rt;
    alu_op         = r_held.alu_op;
    ex_dst         = r_held.dst;
    ex_reg_write   = r_valid && r_held.reg_write;
    ex_mem_read    = r_valid && r_held.mem_read;
    ex_mem_write   = r_valid && r_held.mem_write;
    load_use_stall = w_hazard;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instructions, expected EX transfers queued
// at issue and checked by an independent monitor, plus direct checks of
// handshake, hazard, flush and reset behaviour.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dst;
  logic        id_use_rs;
  logic        id_use_rt;
  alu_op_t     id_alu_op;
  logic        id_alusrc_imm;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dst;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dst;
  logic [31:0] memwb_result;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_t     alu_op;
  logic [31:0] store_data;
  logic [4:0]  ex_dst;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        load_use_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t exp_q[$];

  id_ex_stage #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_dst          (id_dst),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_alu_op       (id_alu_op),
    .id_alusrc_imm   (id_alusrc_imm),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst       (exmem_dst),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst       (memwb_dst),
    .memwb_result    (memwb_result),
    .ex_ready        (ex_ready),
    .ex_valid        (ex_valid),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_op          (alu_op),
    .store_data      (store_data),
    .ex_dst          (ex_dst),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .load_use_stall  (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                          input logic urs, input logic urt,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input alu_op_t op, input logic asrc,
                          input logic rw, input logic mr, input logic mw);
    id_valid      = 1'b1;
    id_rs         = rs;
    id_rt         = rt;
    id_dst        = dst;
    id_use_rs     = urs;
    id_use_rt     = urt;
    id_rs_data    = rsd;
    id_rt_data    = rtd;
    id_imm        = imm;
    id_alu_op     = op;
    id_alusrc_imm = asrc;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_write  = mw;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input alu_op_t op,
                      input logic [31:0] sd, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.sd = sd; e.dst = dst; e.rw = rw; e.mr = mr; e.mw = mw;
    exp_q.push_back(e);
  endtask

  // Monitor: every instruction EX accepts (and that is not being flushed)
  // must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready && !flush) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: actual dst=%0d a=%h required=no transfer",
                 ex_dst, alu_a);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (alu_a !== e.a || alu_b !== e.b || alu_op !== e.op || store_data !== e.sd ||
            ex_dst !== e.dst || ex_reg_write !== e.rw || ex_mem_read !== e.mr ||
            ex_mem_write !== e.mw) begin
          bad++;
          $display("FAIL xfer: actual a=%h b=%h op=%0d sd=%h dst=%0d rw=%b mr=%b mw=%b required a=%h b=%h op=%0d sd=%h dst=%0d rw=%b mr=%b mw=%b",
                   alu_a, alu_b, alu_op, store_data, ex_dst, ex_reg_write, ex_mem_read,
                   ex_mem_write, e.a, e.b, e.op, e.sd, e.dst, e.rw, e.mr, e.mw);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_dst = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_alu_op = ALU_ADD; id_alusrc_imm = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    exmem_reg_write = 1'b0; exmem_dst = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_dst = '0; memwb_result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_ex_dst", {27'd0, ex_dst}, 32'd0);
    chk("rst_stall", {31'd0, load_use_stall}, 32'd0);

    // add $3,$1,$2 with no forwarding
    tick();
    drive_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'd5, 32'd7, ALU_ADD, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_ex_dst", {27'd0, ex_dst}, 32'd3);

    // Forwarding priority on a held rs=$4
    tick();
    ex_ready = 1'b0;
    exmem_reg_write = 1'b1; exmem_dst = 5'd4; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_dst = 5'd4; memwb_result = 32'h22;
    drive_id(5'd4, 5'd0, 5'd7, 1'b1, 1'b0, 32'h44, 32'h55, 32'd0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("fwd_exmem_wins", alu_a, 32'h11);
    chk("fwd_rt0_b", alu_b, 32'h55);
    chk("hold_id_ready", {31'd0, id_ready}, 32'd0);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", alu_a, 32'h22);
    tick();
    push(32'h22, 32'h55, ALU_OR, 32'h55, 5'd7, 1'b1, 1'b0, 1'b0);
    ex_ready = 1'b1;
    @(negedge clk);

    // $0 is never forwarded
    tick();
    exmem_reg_write = 1'b1; exmem_dst = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1'b1; memwb_dst = 5'd0; memwb_result = 32'hBEEF;
    drive_id(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h33, 32'h66, 32'd0, ALU_AND, 1'b0, 1'b1, 1'b0,
             1'b0);
    push(32'h33, 32'h66, ALU_AND, 32'h66, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("fwd_zero", alu_a, 32'h33);

    // Load-use: lw $5 held, sub $6,$5,$1 presented
    tick();
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    drive_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h100, 32'd0, 32'd4, ALU_ADD, 1'b1, 1'b1, 1'b1,
             1'b0);
    push(32'h100, 32'd4, ALU_ADD, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    push(32'h99, 32'd3, ALU_SUB, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 32'd0, 32'd3, 32'd0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    exmem_reg_write = 1'b1; exmem_dst = 5'd5; exmem_result = 32'h99;
    @(negedge clk);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_clear", {31'd0, load_use_stall}, 32'd0);
    chk("lu_ready_again", {31'd0, id_ready}, 32'd1);
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("lu_sub_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
    chk("lu_sub_fwd", alu_a, 32'h99);

    // Downstream stall with ID waiting, then flush with a would-be transfer
    tick();
    exmem_reg_write = 1'b0;
    ex_ready = 1'b0;
    drive_id(5'd2, 5'd3, 5'd10, 1'b1, 1'b1, 32'hA, 32'hB, 32'd0, ALU_XOR, 1'b0, 1'b1, 1'b0,
             1'b0);
    tick();
    drive_id(5'd1, 5'd1, 5'd11, 1'b1, 1'b1, 32'h1, 32'h2, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0,
             1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
      chk("stall_valid", {31'd0, ex_valid}, 32'd1);
      chk("stall_a", alu_a, 32'hA);
      chk("stall_b", alu_b, 32'hB);
      chk("stall_dst", {27'd0, ex_dst}, 32'd10);
    end
    tick();
    flush = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_not_captured", {27'd0, ex_dst}, 32'd10);
    chk("flush_a_kept", alu_a, 32'hA);
    chk("flush_rw_gated", {31'd0, ex_reg_write}, 32'd0);

    // Store with immediate B and MEM/WB-forwarded store data, then async reset
    tick();
    ex_ready = 1'b0;
    memwb_reg_write = 1'b1; memwb_dst = 5'd8; memwb_result = 32'hAB;
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 32'h200, 32'h1, 32'h10, ALU_ADD, 1'b1, 1'b0, 1'b0,
             1'b1);
    tick();
    id_valid = 1'b0;
    @(negedge clk);
    chk("sw_alu_a", alu_a, 32'h200);
    chk("sw_alu_b_imm", alu_b, 32'h10);
    chk("sw_store_data", store_data, 32'hAB);
    chk("sw_mem_write", {31'd0, ex_mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_store_data", store_data, 32'd0);
    chk("arst_mem_write", {31'd0, ex_mem_write}, 32'd0);
    chk("arst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    tick();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
